// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampled UART receiver.
// UART_RX_PARITY_EN (optional) adds an even-parity bit between data and stop.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Level of an idle serial line (also the stop-bit level)
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Serial-side and byte-side signals of the UART receiver.
// UART_RX_PARITY_EN adds the Parity_Err status line.
interface uart_rx_oversampled_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic                 Baud_Tick;
  logic                 Rx_In;
  logic [DATA_BITS-1:0] Rx_Data;
  logic                 Rx_Valid;
  logic                 Frame_Err;
  logic                 Busy;
`ifdef UART_RX_PARITY_EN
  logic                 Parity_Err;
`endif

  // Driver side: supplies the baud enable and the serial line
  modport master (
    output Baud_Tick,
    output Rx_In,
    input  Rx_Data,
    input  Rx_Valid,
    input  Frame_Err,
`ifdef UART_RX_PARITY_EN
    input  Parity_Err,
`endif
    input  Busy
  );

  // Receiver side
  modport slave (
    input  Baud_Tick,
    input  Rx_In,
    output Rx_Data,
    output Rx_Valid,
    output Frame_Err,
`ifdef UART_RX_PARITY_EN
    output Parity_Err,
`endif
    output Busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic Clock_In,
  input  logic Reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  always_ff @(posedge Clock_In) begin
    if (Reset) begin
      meta_q   <= UART_IDLE_LEVEL;
      sync_out <= UART_IDLE_LEVEL;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: finds mid-bit points from Baud_Tick and deserialises LSB-first frames.
// UART_RX_PARITY_EN adds an even-parity bit and the Parity_Err output.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  Clock_In,
  input  logic                  Reset,
  uart_rx_oversampled_if.slave  bus
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] rx_data, data_nxt;
  logic                 rx_valid, valid_nxt;
  logic                 frame_err, ferr_nxt;
  logic                 busy, busy_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_bit_nxt;
  logic                 parity_err, perr_nxt;
`endif

  uart_rx_sync u_sync (
    .Clock_In (Clock_In),
    .Reset    (Reset),
    .async_in (bus.Rx_In),
    .sync_out (rx_s)
  );

  // State and datapath registers
  always_ff @(posedge Clock_In) begin
    if (Reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= busy_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_nxt;
      parity_err <= perr_nxt;
`endif
    end
  end

  // Next state; nothing but the valid strobe moves without a baud tick
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    data_nxt  = rx_data;
    ferr_nxt  = frame_err;
    valid_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
    perr_nxt    = parity_err;
`endif
    if (bus.Baud_Tick) begin
      tick_nxt = tick_cnt + TICK_W'(1);
      unique case (state)
        IDLE: begin
          tick_nxt = '0;
          if (rx_s != UART_IDLE_LEVEL) state_nxt = START;
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_nxt  = '0;
            state_nxt = (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            tick_nxt  = '0;
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt + BIT_W'(1);
            if (bit_cnt == DATA_LAST) begin
              bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == BIT_LAST) begin
            tick_nxt    = '0;
            par_bit_nxt = rx_s;
            state_nxt   = STOP;
          end
        end
`endif
        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            tick_nxt  = '0;
            data_nxt  = shreg;
            ferr_nxt  = (rx_s != UART_IDLE_LEVEL);
            valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_nxt  = ((^shreg) != par_bit);
`endif
            state_nxt = (rx_s == UART_IDLE_LEVEL) ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          tick_nxt = '0;
          if (rx_s == UART_IDLE_LEVEL) state_nxt = IDLE;
        end
        default: begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
    busy_nxt = state_nxt inside {START, DATA, PARITY, STOP};
  end

  assign bus.Rx_Data   = rx_data;
  assign bus.Rx_Valid  = rx_valid;
  assign bus.Frame_Err = frame_err;
  assign bus.Busy      = busy;
`ifdef UART_RX_PARITY_EN
  assign bus.Parity_Err = parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frames are queued on a scoreboard and checked on Rx_Valid.
// Define UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_rx_oversampled;

  localparam int unsigned BIT_CYC = 64;  // 16 ticks x 4 clocks

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   bt_cnt = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  uart_rx_oversampled_if #(.DATA_BITS(8)) bus ();

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .Clock_In (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // One-cycle baud enable every fourth clock
  initial begin
    bus.Baud_Tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.Baud_Tick = (bt_cnt == 3);
      bt_cnt = (bt_cnt + 1) % 4;
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.Rx_In = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  // Queue the expected result, then drive start, data LSB first, [parity], stop
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    e.data = d;
    e.ferr = ~stop;
    e.perr = ((^d) != par);
    sb.push_back(e);
    send_bit(1'b0);
    check_bit("busy_in_frame", bus.Busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  // Output monitor: every strobe must match the oldest queued frame
  always @(negedge clk) begin
    if (bus.Rx_Valid === 1'b1) begin
      exp_t e;
      pulses++;
      check_bit("valid_single_cycle", prev_valid, 1'b0);
      check_bit("valid_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_byte("rx_data", bus.Rx_Data, e.data);
        check_bit("frame_err", bus.Frame_Err, e.ferr);
        check_bit("busy_at_valid", bus.Busy, 1'b0);
`ifdef UART_RX_PARITY_EN
        check_bit("parity_err", bus.Parity_Err, e.perr);
`endif
      end
    end
    prev_valid = bus.Rx_Valid;
  end

  initial begin
    rst = 1'b1;
    bus.Rx_In = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_byte("reset_rx_data", bus.Rx_Data, 8'h00);
    check_bit("reset_rx_valid", bus.Rx_Valid, 1'b0);
    check_bit("reset_frame_err", bus.Frame_Err, 1'b0);
    check_bit("reset_busy", bus.Busy, 1'b0);
    repeat (BIT_CYC) @(negedge clk);

    // Plain frame
    send_frame(8'hA5, 1'b1, 1'b0);
    check_int("pulses_after_a5", pulses, 1);
    check_bit("busy_after_a5", bus.Busy, 1'b0);
    repeat (BIT_CYC) @(negedge clk);

    // Short low glitch is rejected at the mid-start sample
    bus.Rx_In = 1'b0;
    repeat (12) @(negedge clk);
    check_bit("busy_during_glitch", bus.Busy, 1'b1);
    repeat (4) @(negedge clk);
    bus.Rx_In = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    check_bit("busy_after_glitch", bus.Busy, 1'b0);
    check_byte("data_after_glitch", bus.Rx_Data, 8'hA5);
    check_int("pulses_after_glitch", pulses, 1);

    // Framing error followed by a break, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0);
    check_int("pulses_after_3c", pulses, 2);
    bus.Rx_In = 1'b0;
    repeat (40 * 4) @(negedge clk);
    check_int("pulses_during_break", pulses, 2);
    check_bit("busy_during_break", bus.Busy, 1'b0);
    send_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    check_int("pulses_after_81", pulses, 3);
    repeat (BIT_CYC) @(negedge clk);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check_int("pulses_after_b2b", pulses, 5);
    repeat (BIT_CYC) @(negedge clk);

    // Reset mid-frame after three data bits of 0x12
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check_bit("busy_before_reset", bus.Busy, 1'b1);
    rst = 1'b1;
    bus.Rx_In = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_byte("midreset_rx_data", bus.Rx_Data, 8'h00);
    check_bit("midreset_rx_valid", bus.Rx_Valid, 1'b0);
    check_bit("midreset_frame_err", bus.Frame_Err, 1'b0);
    check_bit("midreset_busy", bus.Busy, 1'b0);
    repeat (BIT_CYC) @(negedge clk);
    check_int("pulses_after_reset", pulses, 5);
    send_frame(8'h5A, 1'b1, 1'b0);
    check_int("pulses_after_5a", pulses, 6);
    repeat (BIT_CYC) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has odd weight, so a 0 parity bit is an error
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    check_int("pulses_after_parity", pulses, 8);
    repeat (BIT_CYC) @(negedge clk);
`endif

    check_int("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
